// File: rtl/i3c_pkg.sv
// Shared I3C definitions: TX serializer state encoding and T-bit values.
package i3c_pkg;

   // Serializer FSM states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      SHIFT   = 3'd2,
      TBIT    = 3'd3,
      RELEASE = 3'd4
   } tx_ser_state_e;

   // T-bit on a private read: 1 = controller may keep reading, 0 = end of data
   localparam logic I3C_TBIT_MORE = 1'b1;
   localparam logic I3C_TBIT_END  = 1'b0;

   // Saturating increment for 16-bit status counters
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/i3c_tx_byte_serializer.sv
// I3C SDR private-read byte serializer. Takes bytes from the TTI TX width
// converter and shifts them MSB-first onto SDA, one bit per bit_tick_i
// (SCL falling edge), appending the T-bit after every byte.
// Optional build macro I3C_TX_SER_BYTE_CNT_EN adds tx_byte_cnt_o, a
// saturating count of bytes whose T-bit has been driven since start_i.
module i3c_tx_byte_serializer
   import i3c_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic        bit_tick_i,
   input  logic        sink_valid_i,
   output logic        sink_ready_o,
   input  logic [7:0]  sink_data_i,
   input  logic        sink_last_i,
   output logic        sda_o,
   output logic        sda_oe_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        underrun_o
`ifdef I3C_TX_SER_BYTE_CNT_EN
   ,
   output logic [15:0] tx_byte_cnt_o
`endif
);

   tx_ser_state_e state_q;
   logic [7:0]    shreg_q;
   logic [2:0]    bit_cnt_q;
   logic          last_q;
   logic          sda_q;
   logic          sda_oe_q;
   logic          done_q;
   logic          underrun_q;
   logic          handshake;

   // Ready only while waiting for a byte; an abort (or reset) in the same
   // cycle suppresses it so no byte is consumed and then thrown away.
   assign sink_ready_o = (state_q == FETCH) && !abort_i && !rst_i;
   assign handshake    = sink_valid_i && sink_ready_o;

   assign busy_o     = (state_q != IDLE);
   assign sda_o      = sda_q;
   assign sda_oe_o   = sda_oe_q;
   assign done_o     = done_q;
   assign underrun_o = underrun_q;

   // Main FSM: byte fetch, bit shifting, T-bit and bus release
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         shreg_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         last_q     <= 1'b0;
         sda_q      <= 1'b1;
         sda_oe_q   <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         if (abort_i) begin
            state_q  <= IDLE;
            sda_q    <= 1'b1;
            sda_oe_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_i) state_q <= FETCH;
               end
               FETCH: begin
                  if (handshake) begin
                     shreg_q <= sink_data_i;
                     last_q  <= sink_last_i;
                     state_q <= SHIFT;
                     if (bit_tick_i) begin
                        // byte arrives just in time: MSB goes out straight away
                        sda_q     <= sink_data_i[7];
                        sda_oe_q  <= 1'b1;
                        bit_cnt_q <= 3'd6;
                     end else begin
                        bit_cnt_q <= 3'd7;
                     end
                  end else if (bit_tick_i) begin
                     // bus wants a bit we do not have: release SDA and give up
                     underrun_q <= 1'b1;
                     sda_q      <= 1'b1;
                     sda_oe_q   <= 1'b0;
                     state_q    <= IDLE;
                  end
               end
               SHIFT: begin
                  if (bit_tick_i) begin
                     sda_q    <= shreg_q[bit_cnt_q];
                     sda_oe_q <= 1'b1;
                     if (bit_cnt_q == 3'd0) state_q <= TBIT;
                     else                   bit_cnt_q <= bit_cnt_q - 3'd1;
                  end
               end
               TBIT: begin
                  if (bit_tick_i) begin
                     sda_q   <= last_q ? I3C_TBIT_END : I3C_TBIT_MORE;
                     state_q <= last_q ? RELEASE : FETCH;
                  end
               end
               RELEASE: begin
                  if (bit_tick_i) begin
                     sda_q    <= 1'b1;
                     sda_oe_q <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= IDLE;
                  end
               end
               default: begin
                  state_q  <= IDLE;
                  sda_q    <= 1'b1;
                  sda_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef I3C_TX_SER_BYTE_CNT_EN
   logic [15:0] byte_cnt_q;
   logic [15:0] byte_cnt_d;

   // Next count: clear on an accepted start, bump when a T-bit goes out
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      if (!abort_i) begin
         if (state_q == IDLE && start_i)          byte_cnt_d = 16'h0000;
         else if (state_q == TBIT && bit_tick_i)  byte_cnt_d = sat_inc16(byte_cnt_q);
      end
   end

   // Byte counter register; held across done/abort until the next start
   always_ff @(posedge clk_i) begin
      if (rst_i) byte_cnt_q <= 16'h0000;
      else       byte_cnt_q <= byte_cnt_d;
   end

   assign tx_byte_cnt_o = byte_cnt_q;
`endif

endmodule

// File: tb/tb_i3c_tx_byte_serializer.sv
// Self-checking bench for i3c_tx_byte_serializer: directed scenarios with
// literal bit patterns plus randomized transfers against a bit-queue model.
module tb_i3c_tx_byte_serializer;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i, abort_i, bit_tick_i;
   logic        sink_valid_i, sink_ready_o, sink_last_i;
   logic [7:0]  sink_data_i;
   logic        sda_o, sda_oe_o, busy_o, done_o, underrun_o;
`ifdef I3C_TX_SER_BYTE_CNT_EN
   logic [15:0] tx_byte_cnt_o;
`endif

   i3c_tx_byte_serializer dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .bit_tick_i(bit_tick_i), .sink_valid_i(sink_valid_i),
      .sink_ready_o(sink_ready_o), .sink_data_i(sink_data_i),
      .sink_last_i(sink_last_i), .sda_o(sda_o), .sda_oe_o(sda_oe_o),
      .busy_o(busy_o), .done_o(done_o), .underrun_o(underrun_o)
`ifdef I3C_TX_SER_BYTE_CNT_EN
      , .tx_byte_cnt_o(tx_byte_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [7:0] d; logic l; } byte_t;

   int    checks = 0, errors = 0;
   byte_t src_q[$];
   int    hs_total = 0, popped = 0, dcnt = 0, ucnt = 0;
   bit    src_gap = 0;
   logic  cap[$];

   // model: transfer active flag, pending bits of the current byte, release flag
   logic  m_active, m_rel, m_last, m_sda, m_oe, m_done, m_under;
   logic  m_bits[$];
   logic [15:0] m_cnt;
   bit    chk_en = 0;
   logic  prev_tick = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // compare DUT with model, then advance the model using this cycle's inputs
   always @(negedge clk_i) begin
      logic exp_ready, hs;
      if (chk_en) begin
         chk("sda", sda_o, m_sda);
         chk("sda_oe", sda_oe_o, m_oe);
         chk("busy", busy_o, m_active);
         chk("done", done_o, m_done);
         chk("underrun", underrun_o, m_under);
`ifdef I3C_TX_SER_BYTE_CNT_EN
         chk("byte_cnt", tx_byte_cnt_o, m_cnt);
`endif
         if (prev_tick) cap.push_back(sda_o);
         if (done_o) dcnt++;
         if (underrun_o) ucnt++;
      end
      exp_ready = m_active && !m_rel && (m_bits.size() == 0) && !abort_i && !rst_i;
      if (chk_en) chk("ready", sink_ready_o, exp_ready);
      if (sink_valid_i && sink_ready_o) hs_total++;
      hs = sink_valid_i && exp_ready;
      m_done = 0; m_under = 0;
      if (rst_i) begin
         m_active = 0; m_rel = 0; m_bits.delete(); m_sda = 1; m_oe = 0;
         m_cnt = 0; m_last = 0; chk_en = 1;
      end else if (abort_i) begin
         m_active = 0; m_rel = 0; m_bits.delete(); m_oe = 0; m_sda = 1;
      end else if (!m_active) begin
         if (start_i) begin m_active = 1; m_cnt = 0; end
      end else if (m_rel) begin
         if (bit_tick_i) begin m_oe = 0; m_sda = 1; m_done = 1; m_active = 0; m_rel = 0; end
      end else begin
         if (m_bits.size() == 0) begin
            if (hs) begin
               for (int i = 7; i >= 0; i--) m_bits.push_back(sink_data_i[i]);
               m_bits.push_back(!sink_last_i);
               m_last = sink_last_i;
            end else if (bit_tick_i) begin
               m_under = 1; m_oe = 0; m_sda = 1; m_active = 0;
            end
         end
         if (bit_tick_i && m_bits.size() > 0) begin
            m_sda = m_bits.pop_front();
            m_oe = 1;
            if (m_bits.size() == 0) begin
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
               if (m_last) m_rel = 1;
            end
         end
      end
      prev_tick = bit_tick_i;
   end

   // byte source: presents queue head, retires it once a handshake was seen
   always @(posedge clk_i) begin
      #2;
      while (popped < hs_total) begin
         if (src_q.size() > 0) void'(src_q.pop_front());
         popped++;
      end
      if (src_q.size() > 0 && (!src_gap || $urandom_range(7) != 0)) begin
         sink_valid_i = 1; sink_data_i = src_q[0].d; sink_last_i = src_q[0].l;
      end else begin
         sink_valid_i = 0; sink_data_i = 8'($urandom); sink_last_i = 1'($urandom);
      end
   end

   task automatic cyc();
      @(posedge clk_i); #1;
   endtask

   task automatic push_b(input logic [7:0] d, input logic l);
      byte_t b;
      b.d = d; b.l = l;
      src_q.push_back(b);
   endtask

   task automatic start_pulse();
      start_i = 1; cyc(); start_i = 0;
   endtask

   task automatic tick_gap();
      bit_tick_i = 1; cyc(); bit_tick_i = 0; cyc();
   endtask

   task automatic chk_cap(input string nm, input logic [31:0] pat, input int n);
      chk({nm, "_len"}, cap.size(), n);
      for (int i = 0; i < n && i < cap.size(); i++) chk({nm, "_bit"}, cap[i], pat[n-1-i]);
   endtask

   task automatic flush();
      src_q.delete(); cyc(); cyc();
   endtask

   initial begin
      int d0, h0, u0, n;
      rst_i = 1; start_i = 0; abort_i = 0; bit_tick_i = 0;
      sink_valid_i = 0; sink_data_i = 0; sink_last_i = 0;
      repeat (3) cyc();
      rst_i = 0; cyc();
      chk("rst_sda", sda_o, 1'b1);
      chk("rst_oe", sda_oe_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_ready", sink_ready_o, 1'b0);

      // single byte 0xA5, last
      cap.delete(); d0 = dcnt; h0 = hs_total;
      push_b(8'hA5, 1); cyc(); start_pulse(); cyc();
      repeat (10) tick_gap();
      chk_cap("a5", 32'b1010010101, 10);
      chk("a5_done", dcnt - d0, 1);
      chk("a5_hs", hs_total - h0, 1);
      chk("a5_oe", sda_oe_o, 1'b0);

      // two bytes 0x3C, 0xFF
      cap.delete(); d0 = dcnt; h0 = hs_total;
      push_b(8'h3C, 0); push_b(8'hFF, 1); cyc(); start_pulse(); cyc();
      repeat (19) tick_gap();
      chk_cap("two", 32'b0011110011111111101, 19);
      chk("two_done", dcnt - d0, 1);
      chk("two_hs", hs_total - h0, 2);

      // underrun: tick with no byte
      d0 = dcnt; u0 = ucnt;
      start_pulse(); bit_tick_i = 1; cyc(); bit_tick_i = 0;
      chk("ur_pulse", underrun_o, 1'b1);
      chk("ur_busy", busy_o, 1'b0);
      chk("ur_oe", sda_oe_o, 1'b0);
      cyc();
      chk("ur_cnt", ucnt - u0, 1);
      chk("ur_nodone", dcnt - d0, 0);

      // same-cycle load and tick with 0x80
      cap.delete();
      push_b(8'h80, 1); cyc(); start_pulse();
      bit_tick_i = 1; cyc(); bit_tick_i = 0;
      chk("sc_sda", sda_o, 1'b1);
      chk("sc_oe", sda_oe_o, 1'b1);
      cyc();
      repeat (9) tick_gap();
      chk_cap("sc", 32'b1000000001, 10);

      // abort right after first T-bit of 0x55/0x66
      cap.delete(); d0 = dcnt; h0 = hs_total;
      push_b(8'h55, 0); push_b(8'h66, 1); cyc(); start_pulse(); cyc();
      repeat (8) tick_gap();
      bit_tick_i = 1; cyc(); bit_tick_i = 0;
      abort_i = 1; cyc(); abort_i = 0;
      chk("ab_busy", busy_o, 1'b0);
      chk("ab_oe", sda_oe_o, 1'b0);
      chk("ab_sda", sda_o, 1'b1);
      cyc();
      chk_cap("ab", 32'b010101011, 9);
      chk("ab_hs", hs_total - h0, 1);
      chk("ab_left", src_q.size(), 1);
      chk("ab_nodone", dcnt - d0, 0);
      flush();

      // reset in the middle of a byte
      push_b(8'hC3, 1); cyc(); start_pulse(); cyc();
      repeat (3) tick_gap();
      rst_i = 1; cyc(); rst_i = 0;
      chk("mr_busy", busy_o, 1'b0);
      chk("mr_oe", sda_oe_o, 1'b0);
      flush();

`ifdef I3C_TX_SER_BYTE_CNT_EN
      push_b(8'h11, 0); push_b(8'h22, 0); push_b(8'h33, 1); cyc(); start_pulse(); cyc();
      repeat (28) tick_gap();
      chk("cnt_three", tx_byte_cnt_o, 16'd3);
      start_pulse();
      chk("cnt_clear", tx_byte_cnt_o, 16'd0);
      abort_i = 1; cyc(); abort_i = 0; flush();
`endif

      // randomized transfers: random bytes, tick spacing, valid gaps, aborts
      src_gap = 1;
      for (int t = 0; t < 40; t++) begin
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) push_b(8'($urandom), k == n - 1);
         cyc(); start_pulse();
         for (int c = 0; c < 400; c++) begin
            if (!busy_o) break;
            bit_tick_i = 1'($urandom_range(1));
            abort_i    = ($urandom_range(150) == 0);
            start_i    = ($urandom_range(40) == 0);
            cyc();
            bit_tick_i = 0; abort_i = 0; start_i = 0;
         end
         chk("rand_ends", busy_o, 1'b0);
         flush();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
